sample_sched: RTL and testbench
===============================

Name: sample_sched

Overview:
- Periodic sampling scheduler for NUM independent sampled channels.
- Each channel keeps a hold-last-value register that always accepts input.
- A free-running period counter triggers a coherent snapshot of all held values. The snapshot is then serialised onto one shared output stream as a frame: one beat per valid channel, tagged with channel index and a last flag.
- Sits between multiple sensor/status producers and a single downstream consumer that must see time-aligned channel sets.

Parameters:
- NUM, 4, number of input channels (1..16).
- W, 16, data width per channel.
- PERIOD, 8, cycles between snapshot ticks (>=2).
- INIT, 0, reset value loaded into every hold register when INIT_VALID=1.
- INIT_VALID, 0, if 1 all channels are valid after reset.
- CNT_W, 8, overrun counter width.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous, active-low reset (rst==0 resets on the clock edge).
- din_data  in  NUM*W  channel i at bits [i*W +: W].
- din_valid  in  NUM  per-channel valid.
- din_ready  out  NUM  per-channel ready; constant all-ones.
- dout_data  out  W  snapshot value of current channel.
- dout_ch  out  $clog2(NUM) (min 1)  channel index of current beat.
- dout_last  out  1  current beat is the last of the frame.
- dout_valid  out  1  output valid.
- dout_ready  in  1  downstream ready.
- busy  out  1  frame in progress (state EMIT).
- overrun_cnt  out  CNT_W  saturating count of dropped ticks.

Behaviour:
- Reset (rst==0 at edge):
  - hold[i] = INIT if INIT_VALID else 0; hvalid[i] = INIT_VALID.
  - tick counter = 0; state = IDLE.
  - dout_valid = 0, busy = 0, dout_last = 0, dout_ch = 0, dout_data = 0, overrun_cnt = 0.
  - Reset mid-frame aborts the frame with no further beats.
- Hold registers: din_valid[i] -> hold[i] <= din_data[i], hvalid[i] <= 1. hvalid never clears except by reset.
- Tick counter: increments each cycle and wraps PERIOD-1 -> 0. tick = (cnt == PERIOD-1). The first tick is in the PERIOD-th cycle after reset release.
- Snapshot on an accepted tick:
  - snap[i] <= din_valid[i] ? din_data[i] : hold[i].
  - mask[i] <= hvalid[i] | din_valid[i]. Same-cycle input is bypassed into the snapshot.
- FSM states IDLE and EMIT.
  - IDLE + tick:
    - mask (as computed) all zero -> stay IDLE; no output, no overrun.
    - otherwise go to EMIT with ch = lowest set bit of mask.
  - EMIT outputs, all registered:
    - dout_valid = 1, dout_ch = ch, dout_data = snap[ch].
    - dout_last = 1 iff no mask bit above ch is set.
  - EMIT + handshake (dout_valid & dout_ready):
    - not last -> ch = next higher set bit; channels with mask=0 are skipped with no bubble.
    - last -> IDLE.
  - dout_valid stays high and all dout fields stay stable until handshake.
- Latency: tick at cycle T -> first beat valid at T+1. Back-to-back beats at one per cycle while dout_ready=1.
- Tick while in EMIT and not coincident with a last-beat handshake:
  - tick is dropped; the snapshot is unchanged.
  - overrun_cnt increments and saturates at 2^CNT_W-1.
- Tick coincident with a last-beat handshake: not an overrun. The new snapshot is taken and the FSM stays in EMIT with the new frame's first channel next cycle.
- Hold updates during EMIT do not affect the current frame; they only change hold/hvalid.
- busy = (state == EMIT).

Test Plan:
- Reset state:
  - Stimulus: NUM=4, W=16, PERIOD=8, INIT_VALID=0; rst low 3 cycles, no input.
  - Required: dout_valid=0 throughout; no beats at ticks; overrun_cnt=0; din_ready=4'b1111.
- Basic frame:
  - Stimulus: load ch0=0x0011, ch2=0x0022, ch3=0x0033; dout_ready=1.
  - Required: the tick at cycle T yields beats (ch0,0x0011,last0) at T+1, (ch2,0x0022,last0) at T+2, (ch3,0x0033,last1) at T+3. No ch1 beat.
- Coherence:
  - Stimulus: during the frame above, write ch3=0x0099 at cycle T+1.
  - Required: the ch3 beat still carries 0x0033. The next frame's ch3 beat carries 0x0099.
- Bypass:
  - Stimulus: din_valid[1] with 0x00AA in the tick cycle, ch1 previously invalid.
  - Required: the frame includes a ch1 beat with 0x00AA.
- Backpressure/overrun:
  - Stimulus: dout_ready=0 for 20 cycles with PERIOD=8.
  - Required: the first beat is held stable, overrun_cnt reaches 2 (or 3, per tick count in the window); frame content is unchanged after ready rises. With CNT_W=2 and 5 stalled ticks, overrun_cnt saturates at 3.
- Boundary:
  - Stimulus: last-beat handshake coincident with a tick.
  - Required: overrun_cnt unchanged, new frame's first beat next cycle.
  - Stimulus: rst low mid-frame.
  - Required: dout_valid=0 next cycle; INIT_VALID=1/INIT=0x5 gives a first frame of all channels with 0x0005.

Source files
------------

// File: rtl/sample_sched.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// sample_sched
//   Periodic sampling scheduler. Each of NUM channels keeps the last value it
//   was given. Every PERIOD cycles all held values are captured together into
//   a snapshot, which is then streamed out as one frame: one beat per channel
//   that has ever been written, in ascending channel order, last beat flagged.
//
// Ports
//   clk          in   clock, rising edge
//   rst          in   synchronous reset, active low
//   din_data     in   NUM*W   channel i occupies [i*W +: W]
//   din_valid    in   NUM     per-channel write strobe
//   din_ready    out  NUM     always all-ones (hold registers never stall)
//   dout_data    out  W       snapshot value of the current beat
//   dout_ch      out  CH_W    channel index of the current beat
//   dout_last    out  1       current beat closes the frame
//   dout_valid   out  1       beat valid
//   dout_ready   in   1       downstream ready
//   busy         out  1       a frame is being emitted
//   overrun_cnt  out  CNT_W   saturating count of ticks dropped during a frame
// -----------------------------------------------------------------------------
module sample_sched #(
  parameter int NUM        = 4,
  parameter int W          = 16,
  parameter int PERIOD     = 8,
  parameter int INIT       = 0,
  parameter int INIT_VALID = 0,
  parameter int CNT_W      = 8,
  localparam int CH_W      = (NUM > 1) ? $clog2(NUM) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NUM*W-1:0] din_data,
  input  logic [NUM-1:0]   din_valid,
  output logic [NUM-1:0]   din_ready,
  output logic [W-1:0]     dout_data,
  output logic [CH_W-1:0]  dout_ch,
  output logic             dout_last,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             busy,
  output logic [CNT_W-1:0] overrun_cnt
);

  localparam int PC_W = $clog2(PERIOD);

  typedef enum logic {S_IDLE = 1'b0, S_EMIT = 1'b1} state_t;

  // Lowest set bit of m at or above position 'from'.
  function automatic logic [CH_W-1:0] first_from(input logic [NUM-1:0] m,
                                                 input int from);
    logic [CH_W-1:0] idx;
    idx = '0;
    for (int i = NUM - 1; i >= 0; i--) begin
      if (m[i] && (i >= from)) idx = CH_W'(i);
    end
    return idx;
  endfunction

  // True when no bit of m above position ch is set.
  function automatic logic none_above(input logic [NUM-1:0] m,
                                      input logic [CH_W-1:0] ch);
    logic res;
    res = 1'b1;
    for (int i = 0; i < NUM; i++) begin
      if (m[i] && (i > int'(ch))) res = 1'b0;
    end
    return res;
  endfunction

  state_t            r_state;
  state_t            w_state_nxt;
  logic [PC_W-1:0]   r_cnt;
  logic [W-1:0]      r_hold [NUM];
  logic [NUM-1:0]    r_hvalid;
  logic [W-1:0]      r_snap [NUM];
  logic [NUM-1:0]    r_mask;
  logic [CNT_W-1:0]  r_ovr;

  logic              r_dout_valid;
  logic              r_dout_last;
  logic [CH_W-1:0]   r_dout_ch;
  logic [W-1:0]      r_dout_data;

  logic              w_valid_nxt;
  logic              w_last_nxt;
  logic [CH_W-1:0]   w_ch_nxt;
  logic [W-1:0]      w_data_nxt;

  logic [W-1:0]      w_snap_new [NUM];
  logic [NUM-1:0]    w_mask_new;
  logic              w_tick;
  logic              w_hs;
  logic              w_frame_end;
  logic              w_take;
  logic              w_start;
  logic              w_adv;
  logic              w_ovr;

  assign din_ready   = '1;
  assign dout_valid  = r_dout_valid;
  assign dout_last   = r_dout_last;
  assign dout_ch     = r_dout_ch;
  assign dout_data   = r_dout_data;
  assign busy        = (r_state == S_EMIT);
  assign overrun_cnt = r_ovr;

  // Same-cycle writes bypass the hold registers into the snapshot.
  always_comb begin
    for (int i = 0; i < NUM; i++) begin
      w_snap_new[i] = din_valid[i] ? din_data[i*W +: W] : r_hold[i];
    end
  end
  assign w_mask_new = r_hvalid | din_valid;

  assign w_tick      = (r_cnt == PC_W'(PERIOD - 1));
  assign w_hs        = r_dout_valid & dout_ready;
  assign w_frame_end = (r_state == S_EMIT) & w_hs & r_dout_last;
  // A tick is honoured when idle, or when it lands on the closing handshake.
  assign w_take      = w_tick & ((r_state == S_IDLE) | w_frame_end);
  assign w_start     = w_take & (|w_mask_new);
  assign w_adv       = (r_state == S_EMIT) & w_hs & ~r_dout_last;
  assign w_ovr       = w_tick & (r_state == S_EMIT) & ~w_frame_end;

  // Period counter and hold registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt    <= '0;
      r_hvalid <= {NUM{INIT_VALID != 0}};
      for (int i = 0; i < NUM; i++) begin
        r_hold[i] <= (INIT_VALID != 0) ? W'(INIT) : '0;
      end
    end else begin
      r_cnt <= w_tick ? '0 : r_cnt + 1'b1;
      for (int i = 0; i < NUM; i++) begin
        if (din_valid[i]) begin
          r_hold[i]   <= din_data[i*W +: W];
          r_hvalid[i] <= 1'b1;
        end
      end
    end
  end

  // Snapshot capture and overrun counter.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_mask <= '0;
      r_ovr  <= '0;
      for (int i = 0; i < NUM; i++) r_snap[i] <= '0;
    end else begin
      if (w_start) begin
        r_mask <= w_mask_new;
        for (int i = 0; i < NUM; i++) r_snap[i] <= w_snap_new[i];
      end
      if (w_ovr && (r_ovr != {CNT_W{1'b1}})) r_ovr <= r_ovr + 1'b1;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  // FSM next state.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_start) w_state_nxt = S_EMIT;
      S_EMIT: if (w_frame_end) w_state_nxt = w_start ? S_EMIT : S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // FSM outputs (next values of the registered beat fields).
  always_comb begin
    w_valid_nxt = r_dout_valid;
    w_last_nxt  = r_dout_last;
    w_ch_nxt    = r_dout_ch;
    w_data_nxt  = r_dout_data;
    if (w_start) begin
      // New frame: first beat comes straight from the snapshot being taken.
      w_ch_nxt    = first_from(w_mask_new, 0);
      w_data_nxt  = w_snap_new[w_ch_nxt];
      w_last_nxt  = none_above(w_mask_new, w_ch_nxt);
      w_valid_nxt = 1'b1;
    end else if (w_adv) begin
      // Jump directly to the next populated channel, no bubble.
      w_ch_nxt    = first_from(r_mask, int'(r_dout_ch) + 1);
      w_data_nxt  = r_snap[w_ch_nxt];
      w_last_nxt  = none_above(r_mask, w_ch_nxt);
      w_valid_nxt = 1'b1;
    end else if (w_frame_end) begin
      w_valid_nxt = 1'b0;
      w_last_nxt  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_dout_valid <= 1'b0;
      r_dout_last  <= 1'b0;
      r_dout_ch    <= '0;
      r_dout_data  <= '0;
    end else begin
      r_dout_valid <= w_valid_nxt;
      r_dout_last  <= w_last_nxt;
      r_dout_ch    <= w_ch_nxt;
      r_dout_data  <= w_data_nxt;
    end
  end

endmodule

// File: tb/tb_sample_sched.sv
`timescale 1ns/1ps
// Directed bench for sample_sched. Three instances share the clock:
//   A: defaults (NUM=4, W=16, PERIOD=8, CNT_W=8, INIT_VALID=0)
//   B: CNT_W=2 for overrun saturation
//   C: INIT_VALID=1, INIT=5 for the post-reset frame
// Only the instance under test is out of reset at any time.
module tb_sample_sched;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  logic        a_rst, b_rst, c_rst;
  logic [63:0] a_din_data, b_din_data, c_din_data;
  logic [3:0]  a_din_valid, b_din_valid, c_din_valid;
  logic [3:0]  a_din_ready, b_din_ready, c_din_ready;
  logic [15:0] a_dout_data, b_dout_data, c_dout_data;
  logic [1:0]  a_dout_ch, b_dout_ch, c_dout_ch;
  logic        a_dout_last, b_dout_last, c_dout_last;
  logic        a_dout_valid, b_dout_valid, c_dout_valid;
  logic        a_dout_ready, b_dout_ready, c_dout_ready;
  logic        a_busy, b_busy, c_busy;
  logic [7:0]  a_ovr;
  logic [1:0]  b_ovr;
  logic [7:0]  c_ovr;

  sample_sched #(.NUM(4), .W(16), .PERIOD(8), .INIT(0), .INIT_VALID(0), .CNT_W(8)) u_a (
    .clk(clk), .rst(a_rst), .din_data(a_din_data), .din_valid(a_din_valid),
    .din_ready(a_din_ready), .dout_data(a_dout_data), .dout_ch(a_dout_ch),
    .dout_last(a_dout_last), .dout_valid(a_dout_valid), .dout_ready(a_dout_ready),
    .busy(a_busy), .overrun_cnt(a_ovr));

  sample_sched #(.NUM(4), .W(16), .PERIOD(8), .INIT(0), .INIT_VALID(0), .CNT_W(2)) u_b (
    .clk(clk), .rst(b_rst), .din_data(b_din_data), .din_valid(b_din_valid),
    .din_ready(b_din_ready), .dout_data(b_dout_data), .dout_ch(b_dout_ch),
    .dout_last(b_dout_last), .dout_valid(b_dout_valid), .dout_ready(b_dout_ready),
    .busy(b_busy), .overrun_cnt(b_ovr));

  sample_sched #(.NUM(4), .W(16), .PERIOD(8), .INIT(5), .INIT_VALID(1), .CNT_W(8)) u_c (
    .clk(clk), .rst(c_rst), .din_data(c_din_data), .din_valid(c_din_valid),
    .din_ready(c_din_ready), .dout_data(c_dout_data), .dout_ch(c_dout_ch),
    .dout_last(c_dout_last), .dout_valid(c_dout_valid), .dout_ready(c_dout_ready),
    .busy(c_busy), .overrun_cnt(c_ovr));

  // Advance one clock; outputs are sampled 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Advance so that the next edge samples a tick (edges 8, 16, ... after release).
  task automatic step_to_tick();
    while ((cyc % 8) != 7) step();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_beat(input string tag, input logic v, input logic [1:0] ch,
                          input logic [15:0] d, input logic l,
                          input int ech, input int ed, input int el);
    chk({tag, ".valid"}, 32'(v), 1);
    chk({tag, ".ch"},    32'(ch), 32'(ech));
    chk({tag, ".data"},  32'(d), 32'(ed));
    chk({tag, ".last"},  32'(l), 32'(el));
  endtask

  initial begin
    a_rst = 1'b0; b_rst = 1'b0; c_rst = 1'b0;
    a_din_data = '0; b_din_data = '0; c_din_data = '0;
    a_din_valid = '0; b_din_valid = '0; c_din_valid = '0;
    a_dout_ready = 1'b1; b_dout_ready = 1'b1; c_dout_ready = 1'b1;
    #1;

    // ---------------- A: reset state ----------------
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst.valid", 32'(a_dout_valid), 0);
    end
    chk("rst.busy", 32'(a_busy), 0);
    chk("rst.ch",   32'(a_dout_ch), 0);
    chk("rst.data", 32'(a_dout_data), 0);
    chk("rst.last", 32'(a_dout_last), 0);
    chk("rst.ovr",  32'(a_ovr), 0);
    chk("rst.ready", 32'(a_din_ready), 32'hF);
    a_rst = 1'b1; cyc = 0;
    // Two ticks pass with no channel ever written: no beats.
    for (int i = 0; i < 20; i++) begin
      step();
      chk("idle.valid", 32'(a_dout_valid), 0);
    end
    chk("idle.ovr", 32'(a_ovr), 0);

    // ---------------- A: basic frame + coherence ----------------
    a_din_valid = 4'b1101;
    a_din_data[0*16 +: 16] = 16'h0011;
    a_din_data[2*16 +: 16] = 16'h0022;
    a_din_data[3*16 +: 16] = 16'h0033;
    step();
    a_din_valid = '0;
    step_to_tick();
    step();                               // tick edge 24
    chk_beat("f1.b0", a_dout_valid, a_dout_ch, a_dout_data, a_dout_last, 0, 'h11, 0);
    chk("f1.busy", 32'(a_busy), 1);
    a_din_valid = 4'b1000;                // write ch3 mid-frame
    a_din_data[3*16 +: 16] = 16'h0099;
    step();
    a_din_valid = '0;
    chk_beat("f1.b1", a_dout_valid, a_dout_ch, a_dout_data, a_dout_last, 2, 'h22, 0);
    step();
    chk_beat("f1.b2", a_dout_valid, a_dout_ch, a_dout_data, a_dout_last, 3, 'h33, 1);
    step();
    chk("f1.end.valid", 32'(a_dout_valid), 0);
    chk("f1.end.busy",  32'(a_busy), 0);

    // ---------------- A: bypass of ch1 in the tick cycle ----------------
    step_to_tick();
    a_din_valid = 4'b0010;
    a_din_data[1*16 +: 16] = 16'h00AA;
    step();                               // tick edge 32
    a_din_valid = '0;
    chk_beat("f2.b0", a_dout_valid, a_dout_ch, a_dout_data, a_dout_last, 0, 'h11, 0);
    step();
    chk_beat("f2.b1", a_dout_valid, a_dout_ch, a_dout_data, a_dout_last, 1, 'hAA, 0);
    step();
    chk_beat("f2.b2", a_dout_valid, a_dout_ch, a_dout_data, a_dout_last, 2, 'h22, 0);
    step();
    chk_beat("f2.b3", a_dout_valid, a_dout_ch, a_dout_data, a_dout_last, 3, 'h99, 1);
    step();
    chk("f2.end.valid", 32'(a_dout_valid), 0);

    // ---------------- A: backpressure / overrun ----------------
    a_dout_ready = 1'b0;
    step_to_tick();
    step();                               // tick edge 40
    chk_beat("bp.b0", a_dout_valid, a_dout_ch, a_dout_data, a_dout_last, 0, 'h11, 0);
    for (int i = 0; i < 20; i++) begin    // edges 41..60, ticks at 48 and 56 dropped
      if (i == 3) begin
        a_din_valid = 4'b0001;
        a_din_data[0*16 +: 16] = 16'h0077;
      end else begin
        a_din_valid = '0;
      end
      step();
      chk_beat("bp.hold", a_dout_valid, a_dout_ch, a_dout_data, a_dout_last, 0, 'h11, 0);
    end
    a_din_valid = '0;
    chk("bp.ovr", 32'(a_ovr), 2);
    a_dout_ready = 1'b1;
    step();
    chk_beat("bp.b1", a_dout_valid, a_dout_ch, a_dout_data, a_dout_last, 1, 'hAA, 0);
    step();
    chk_beat("bp.b2", a_dout_valid, a_dout_ch, a_dout_data, a_dout_last, 2, 'h22, 0);
    step();
    chk_beat("bp.b3", a_dout_valid, a_dout_ch, a_dout_data, a_dout_last, 3, 'h99, 1);

    // ---------------- A: last-beat handshake coincident with tick ----------------
    step();                               // edge 64: handshake of last beat + tick
    chk_beat("co.b0", a_dout_valid, a_dout_ch, a_dout_data, a_dout_last, 0, 'h77, 0);
    chk("co.ovr", 32'(a_ovr), 2);
    chk("co.busy", 32'(a_busy), 1);
    step();
    chk_beat("co.b1", a_dout_valid, a_dout_ch, a_dout_data, a_dout_last, 1, 'hAA, 0);
    step();
    chk_beat("co.b2", a_dout_valid, a_dout_ch, a_dout_data, a_dout_last, 2, 'h22, 0);
    step();
    chk_beat("co.b3", a_dout_valid, a_dout_ch, a_dout_data, a_dout_last, 3, 'h99, 1);
    step();
    chk("co.end.valid", 32'(a_dout_valid), 0);

    // ---------------- A: reset mid-frame ----------------
    step_to_tick();
    step();
    chk_beat("mr.b0", a_dout_valid, a_dout_ch, a_dout_data, a_dout_last, 0, 'h77, 0);
    a_rst = 1'b0;
    step();
    chk("mr.valid", 32'(a_dout_valid), 0);
    chk("mr.busy",  32'(a_busy), 0);
    chk("mr.ovr",   32'(a_ovr), 0);
    step();
    chk("mr.valid2", 32'(a_dout_valid), 0);

    // ---------------- B: overrun saturation with CNT_W=2 ----------------
    b_rst = 1'b1; cyc = 0;
    b_dout_ready = 1'b0;
    b_din_valid = 4'b0001;
    b_din_data[0*16 +: 16] = 16'h1234;
    step();
    b_din_valid = '0;
    step_to_tick();
    step();                               // tick edge 8
    chk_beat("sat.b0", b_dout_valid, b_dout_ch, b_dout_data, b_dout_last, 0, 'h1234, 1);
    for (int i = 0; i < 24; i++) step();  // edge 32: ticks 16, 24, 32 dropped
    chk("sat.ovr3", 32'(b_ovr), 3);
    for (int i = 0; i < 16; i++) step();  // edge 48: ticks 40, 48 also dropped
    chk("sat.ovr5", 32'(b_ovr), 3);
    chk_beat("sat.hold", b_dout_valid, b_dout_ch, b_dout_data, b_dout_last, 0, 'h1234, 1);
    b_dout_ready = 1'b1;
    step();
    chk("sat.end.valid", 32'(b_dout_valid), 0);
    b_rst = 1'b0;

    // ---------------- C: INIT_VALID=1, INIT=5 ----------------
    c_rst = 1'b1; cyc = 0;
    step();
    chk("iv.pre.valid", 32'(c_dout_valid), 0);
    step_to_tick();
    step();
    chk_beat("iv.b0", c_dout_valid, c_dout_ch, c_dout_data, c_dout_last, 0, 5, 0);
    step();
    chk_beat("iv.b1", c_dout_valid, c_dout_ch, c_dout_data, c_dout_last, 1, 5, 0);
    step();
    chk_beat("iv.b2", c_dout_valid, c_dout_ch, c_dout_data, c_dout_last, 2, 5, 0);
    step();
    chk_beat("iv.b3", c_dout_valid, c_dout_ch, c_dout_data, c_dout_last, 3, 5, 1);
    step();
    chk("iv.end.valid", 32'(c_dout_valid), 0);
    c_rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
